// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: byte-wide local RAM, fixed wait-state insertion,
// and a two-cycle ERROR response for addresses beyond the array.
module ahb_slave_mem #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hburst,
    input  logic              hready,
    input  logic [DATA_W-1:0] hwdata,
    output logic [DATA_W-1:0] hrdata,
    output logic              hreadyout,
    output logic              hresp
);

    localparam int unsigned     IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [2:0]      WS_L    = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [2:0]        burst_q;
    logic              inrange_q;
    logic              dvalid_q;
    logic [DATA_W-1:0] hrdata_q;

    logic              ready_int;
    logic              resp_int;
    logic              accept;
    logic              in_range;
    logic              wr_en;
    logic [DATA_W-1:0] rd_word;

    // Address decode for the incoming address phase.
    assign in_range = {1'b0, haddr} < DEPTH_L;
    // Only take a new address while our own data phase is finishing (or idle).
    assign accept   = hsel & hready & htrans[1] & ready_int;
    // Write commits on the completing (ready) cycle of an in-range write.
    assign wr_en    = (state_q == ST_IDLE) & dvalid_q & write_q & inrange_q;
    // A read overlapping a same-address write sees the bus data, not the stale word.
    assign rd_word  = (wr_en && (addr_q[IDX_W-1:0] == haddr[IDX_W-1:0]))
                      ? hwdata : mem[haddr[IDX_W-1:0]];

    // Burst type and the unused htrans bit are kept only for context.
    logic unused_ok;
    assign unused_ok = &{1'b0, htrans[0], burst_q, addr_q};

    // State register and transfer context.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            burst_q   <= '0;
            inrange_q <= 1'b0;
            dvalid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ready_int) begin
                dvalid_q <= accept;
            end
            if (accept) begin
                addr_q    <= haddr;
                write_q   <= hwrite;
                burst_q   <= hburst;
                inrange_q <= in_range;
            end
        end
    end

    // Next-state and response decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_int = 1'b1;
        resp_int  = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                resp_int = (state_q == ST_ERR2);
                state_d  = ST_IDLE;
                if (accept) begin
                    if (!in_range) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES != 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_L;
                    end
                end
            end
            ST_WAIT: begin
                ready_int = 1'b0;
                cnt_d     = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR1: begin
                ready_int = 1'b0;
                resp_int  = 1'b1;
                state_d   = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data register: loaded so it is valid in the ready cycle of the read.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hrdata_q <= '0;
        end else if (accept && !hwrite) begin
            if (!in_range) begin
                hrdata_q <= '0;
            end else if (WAIT_STATES == 0) begin
                hrdata_q <= rd_word;
            end
        end else if (state_q == ST_WAIT && cnt_q == 3'd1 && !write_q) begin
            hrdata_q <= mem[addr_q[IDX_W-1:0]];
        end
    end

    // Memory array: no reset, contents survive hresetn.
    always_ff @(posedge hclk) begin
        if (wr_en) begin
            mem[addr_q[IDX_W-1:0]] <= hwdata;
        end
    end

    assign hrdata    = hrdata_q;
    assign hreadyout = ready_int;
    assign hresp     = resp_int;

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-Lite slave with a local 8-bit memory array, a configurable number of wait states and an ERROR response. It is the responder end of the bus that ahbmaster drives. One instance sits behind each slave select (hsel_1 / hsel_2). Its hrdata, hreadyout and hresp outputs feed the read-data/ready/response multiplexor on the master side.

Parameters:
ADDR_W, 10, width of haddr
DATA_W, 8, width of hwdata/hrdata
MEM_DEPTH, 256, number of words; addresses >= MEM_DEPTH are out of range
WAIT_STATES, 0, hreadyout-low cycles inserted per valid transfer (0..7)

Ports:
hclk  in  1  bus clock, all logic rising-edge
hresetn  in  1  asynchronous active-low reset
hsel  in  1  slave select from address decoder
haddr  in  ADDR_W  transfer address (address phase)
hwrite  in  1  1=write, 0=read (address phase)
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hburst  in  3  burst type; stored in the transfer context only, no effect on addressing
hready  in  1  bus-level ready (muxed hreadyout of the selected slave)
hwdata  in  DATA_W  write data (data phase)
hrdata  out  DATA_W  read data
hreadyout  out  1  1=data phase completes this cycle
hresp  out  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (async, hresetn=0):
  - hrdata=0, hreadyout=1, hresp=0; FSM=IDLE; wait counter=0; pending-write flag cleared.
  - Memory contents are not cleared.
- Address phase acceptance: hsel & hready & htrans[1].
  - Latch haddr, hwrite, hburst, and range flag (haddr < MEM_DEPTH).
  - IDLE/BUSY, or hsel=0 while hready=1: no transfer; next cycle is a zero-wait OKAY (hreadyout=1, hresp=0).
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: accepted in-range transfer with WAIT_STATES=0 -> stay IDLE; data phase completes next cycle with hreadyout=1.
  - IDLE: accepted in-range transfer with WAIT_STATES>0 -> WAIT; counter loaded with WAIT_STATES.
  - IDLE: accepted out-of-range transfer -> ERR1.
  - WAIT: hreadyout=0, hresp=0, counter decrements each cycle; counter reaching 1 -> IDLE, so exactly WAIT_STATES low cycles, then one hreadyout=1 cycle.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1 -> IDLE (or accepts the next transfer this cycle).
- Read path:
  - hrdata is registered from mem[latched addr] and is valid in the cycle hreadyout=1 of the read data phase.
  - hrdata holds its value between reads; it is not forced to 0.
  - Out-of-range read returns hrdata=0.
- Write path:
  - mem[latched addr] <= hwdata at the rising edge ending the data-phase cycle where hreadyout=1.
  - Out-of-range writes are discarded.
- Pipelining:
  - A new address phase is accepted in the same cycle the previous data phase completes (hready=1).
  - Back-to-back transfers run with no bubble when WAIT_STATES=0.
- Read-after-write forwarding: a read to address A whose address phase overlaps the completing data phase of a write to A returns the new hwdata, not the stale memory word.
- Address phases presented while hready=0 (another slave stalling) are ignored.
- ERROR does not cancel the master's following NONSEQ. Whatever is presented during ERR2 is accepted normally.
- Reset mid-WAIT or mid-ERR: the transfer is aborted, the pending write is dropped, and outputs return to reset values immediately.

Test Plan:
- Zero-wait write then read, WAIT_STATES=0:
  - NONSEQ write 0x005 data 0xA5, then NONSEQ read 0x005 in the next address phase.
  - Required: hreadyout stays 1 throughout, and hrdata=0xA5 in the read data phase (forwarding path).
- WAIT_STATES=2, read of 0x010 preloaded with 0x3C -> hreadyout=0 for exactly 2 cycles, then 1 with hrdata=0x3C, hresp=0.
- Out-of-range write to 0x1FF with MEM_DEPTH=256:
  - Required: ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1).
  - A subsequent read of 0x0FF is unchanged by the write.
- INCR4 burst (NONSEQ 0x020, SEQ 0x021..0x023, data 0x11..0x44), WAIT_STATES=0:
  - Required: four consecutive OKAY beats.
  - Reading the same burst back returns 0x11, 0x22, 0x33, 0x44.
- IDLE/BUSY and hsel=0 cycles interleaved: no memory change, hreadyout=1, hresp=0 every cycle.
- hresetn asserted during the second wait cycle of a write (WAIT_STATES=3):
  - Required: hreadyout=1, hresp=0 immediately, and the target word keeps its old value.
